// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - iterative radix-2 restoring divider for EX-stage DIV/DIVU (optional DIV_ZERO_FAST_EN)
module div_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_validE,
    input  logic             div_signedE,
    input  logic [WIDTH-1:0] src_aE,
    input  logic [WIDTH-1:0] src_bE,
    input  logic             flush_exceptionE,
    input  logic             ext_stall,
    output logic             alu_stallE,
    output logic             div_doneE,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_a_raw;
    logic [WIDTH-1:0] r_res_lo;
    logic [WIDTH-1:0] r_res_hi;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_b_zero;

    logic             w_start;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    logic             w_last;
    logic [WIDTH-1:0] w_fin_lo;
    logic [WIDTH-1:0] w_fin_hi;
    logic             w_alu_stall;
    logic             w_done;

    assign w_start  = (r_state == S_IDLE) & div_validE & ~flush_exceptionE;
    assign w_b_zero = (src_bE == '0);
    assign w_a_mag  = (div_signedE & src_aE[WIDTH-1]) ? -src_aE : src_aE;
    assign w_b_mag  = (div_signedE & src_bE[WIDTH-1]) ? -src_bE : src_bE;

    // One restoring step; the extra top bit lets |b| = 2^(WIDTH-1) compare correctly.
    assign w_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = w_shift - {1'b0, r_div};
    assign w_ge     = ~w_trial[WIDTH];
    assign w_rem_nx = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // Zero divisor bypasses sign fix-up: quotient all ones, remainder is the raw dividend.
    assign w_fin_lo = r_b_zero ? '1 : (r_neg_q ? -w_quo_nx : w_quo_nx);
    assign w_fin_hi = r_b_zero ? r_a_raw : (r_neg_r ? -w_rem_nx : w_rem_nx);

    always_comb begin
        w_next      = r_state;
        w_alu_stall = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_alu_stall = 1'b1;
`ifdef DIV_ZERO_FAST_EN
                    w_next      = w_b_zero ? S_DONE : S_BUSY;
`else
                    w_next      = S_BUSY;
`endif
                end
            end
            S_BUSY: begin
                w_alu_stall = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (!ext_stall) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (flush_exceptionE) begin
            w_next      = S_IDLE;
            w_alu_stall = 1'b0;
            w_done      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_a_raw  <= '0;
            r_res_lo <= '0;
            r_res_hi <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_div    <= w_b_mag;
                        r_quo    <= w_a_mag;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_a_raw  <= src_aE;
                        r_b_zero <= w_b_zero;
                        r_neg_q  <= div_signedE & (src_aE[WIDTH-1] ^ src_bE[WIDTH-1]);
                        r_neg_r  <= div_signedE & src_aE[WIDTH-1];
`ifdef DIV_ZERO_FAST_EN
                        if (w_b_zero) begin
                            r_res_lo <= '1;
                            r_res_hi <= src_aE;
                        end
`endif
                    end
                end
                S_BUSY: begin
                    if (!flush_exceptionE) begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_res_lo <= w_fin_lo;
                            r_res_hi <= w_fin_hi;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign alu_stallE = w_alu_stall & ~rst;
    assign div_doneE  = w_done & ~rst;
    assign result_lo  = r_res_lo;
    assign result_hi  = r_res_hi;
endmodule

// File: tb/tb_div_iter_unit.sv
// tb/tb_div_iter_unit.sv - randomized self-checking bench for div_iter_unit against a magnitude/sign arithmetic model
module tb_div_iter_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_validE = 1'b0;
    logic        div_signedE = 1'b0;
    logic [31:0] src_aE = '0;
    logic [31:0] src_bE = '0;
    logic        flush_exceptionE = 1'b0;
    logic        ext_stall = 1'b0;
    logic        alu_stallE;
    logic        div_doneE;
    logic [31:0] result_lo;
    logic [31:0] result_hi;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_iter_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .div_validE(div_validE),
        .div_signedE(div_signedE),
        .src_aE(src_aE),
        .src_bE(src_bE),
        .flush_exceptionE(flush_exceptionE),
        .ext_stall(ext_stall),
        .alu_stallE(alu_stallE),
        .div_doneE(div_doneE),
        .result_lo(result_lo),
        .result_hi(result_hi)
    );

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit s,
                                  output logic [31:0] lo, output logic [31:0] hi);
        longint unsigned ma, mb, q, r;
        bit nq, nr;
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else begin
            ma = (s && a[31]) ? (64'h1_0000_0000 - 64'(a)) : 64'(a);
            mb = (s && b[31]) ? (64'h1_0000_0000 - 64'(b)) : 64'(b);
            q  = ma / mb;
            r  = ma % mb;
            nq = s && (a[31] ^ b[31]);
            nr = s && a[31];
            lo = nq ? 32'(-q) : 32'(q);
            hi = nr ? 32'(-r) : 32'(r);
        end
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        return (b == 32'd0) ? 1 : 33;
`else
        return (b == 32'd0) ? 33 : 33;
`endif
    endfunction

    // Presents a divide and waits for done; returns at the falling edge of the done cycle.
    task automatic start_wait(input logic [31:0] a, input logic [31:0] b, input bit s,
                              output int lat, output int stalls);
        div_validE  = 1'b1;
        div_signedE = s;
        src_aE      = a;
        src_bE      = b;
        lat         = -1;
        stalls      = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (div_doneE) begin
                lat = i;
                break;
            end
            if (alu_stallE) stalls++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic leave_ex();
        @(posedge clk);
        #1;
        div_validE = 1'b0;
    endtask

    task automatic run_check(input string name, input logic [31:0] a, input logic [31:0] b, input bit s);
        int lat, stalls;
        logic [31:0] elo, ehi;
        model(a, b, s, elo, ehi);
        start_wait(a, b, s, lat, stalls);
        checks++;
        if (lat !== exp_lat(b)) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat(b));
        end
        checks++;
        if (stalls !== exp_lat(b)) begin
            failures++;
            $display("FAIL %s stall_cycles got=%0d exp=%0d", name, stalls, exp_lat(b));
        end
        checks++;
        if (result_lo !== elo || result_hi !== ehi || alu_stallE !== 1'b0) begin
            failures++;
            $display("FAIL %s a=%h b=%h s=%0d got lo=%h hi=%h stall=%b exp lo=%h hi=%h stall=0",
                     name, a, b, s, result_lo, result_hi, alu_stallE, elo, ehi);
        end
        leave_ex();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (alu_stallE !== 1'b0 || div_doneE !== 1'b0 || result_lo !== 32'd0 || result_hi !== 32'd0) begin
            failures++;
            $display("FAIL reset got stall=%b done=%b lo=%h hi=%h exp all 0", alu_stallE, div_doneE, result_lo, result_hi);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_stallE !== 1'b0 || div_doneE !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got stall=%b done=%b exp 0 0", alu_stallE, div_doneE);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        run_check("divu_100_7", 32'd100, 32'd7, 1'b0);
        run_check("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_check("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_check("divu_big", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run_check("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    endtask

    task automatic test_div_zero();
        run_check("divzero_u", 32'h1234_5678, 32'd0, 1'b0);
        run_check("divzero_s", 32'h8765_4321, 32'd0, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        bit s;
        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 9));
                1: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            s = 1'($urandom_range(0, 1));
            run_check("random", a, b, s);
        end
    endtask

    task automatic test_ext_stall();
        int lat, stalls;
        logic [31:0] elo, ehi;
        model(32'd1000, 32'd33, 1'b0, elo, ehi);
        ext_stall = 1'b1;
        start_wait(32'd1000, 32'd33, 1'b0, lat, stalls);
        checks++;
        if (lat !== 33) begin
            failures++;
            $display("FAIL ext_stall_latency got=%0d exp=33", lat);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) ext_stall = 1'b0;
            @(negedge clk);
            checks++;
            if (div_doneE !== 1'b1 || alu_stallE !== 1'b0 || result_lo !== elo || result_hi !== ehi) begin
                failures++;
                $display("FAIL ext_stall_hold cyc=%0d got done=%b stall=%b lo=%h hi=%h exp done=1 stall=0 lo=%h hi=%h",
                         k, div_doneE, alu_stallE, result_lo, result_hi, elo, ehi);
            end
        end
        leave_ex();
        @(negedge clk);
        checks++;
        if (div_doneE !== 1'b0 || alu_stallE !== 1'b0) begin
            failures++;
            $display("FAIL ext_stall_release got done=%b stall=%b exp 0 0", div_doneE, alu_stallE);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush();
        int lat, stalls;
        int seen_done;
        div_validE  = 1'b1;
        div_signedE = 1'b0;
        src_aE      = 32'd5000;
        src_bE      = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        flush_exceptionE = 1'b1;
        @(negedge clk);
        checks++;
        if (alu_stallE !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall got=%b exp=0", alu_stallE);
        end
        @(posedge clk);
        #1;
        flush_exceptionE = 1'b0;
        div_validE       = 1'b0;
        seen_done        = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_doneE || alu_stallE) seen_done++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen_done !== 0) begin
            failures++;
            $display("FAIL flush_no_done got active_cycles=%0d exp=0", seen_done);
        end
        div_validE       = 1'b1;
        flush_exceptionE = 1'b1;
        @(negedge clk);
        checks++;
        if (alu_stallE !== 1'b0) begin
            failures++;
            $display("FAIL flush_vs_start got stall=%b exp=0", alu_stallE);
        end
        @(posedge clk);
        #1;
        div_validE       = 1'b0;
        flush_exceptionE = 1'b0;
        seen_done        = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_doneE || alu_stallE) seen_done++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen_done !== 0) begin
            failures++;
            $display("FAIL flush_vs_start_idle got active_cycles=%0d exp=0", seen_done);
        end
        run_check("after_flush", 32'hFFFF_FF00, 32'd10, 1'b1);
    endtask

    task automatic test_reset_mid();
        int seen;
        div_validE  = 1'b1;
        div_signedE = 1'b0;
        src_aE      = 32'd77;
        src_bE      = 32'd5;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        div_validE = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_stallE !== 1'b0 || div_doneE !== 1'b0 || result_lo !== 32'd0 || result_hi !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid got stall=%b done=%b lo=%h hi=%h exp all 0", alu_stallE, div_doneE, result_lo, result_hi);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (div_doneE) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_done got done_cycles=%0d exp=0", seen);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, st;
        logic [31:0] elo, ehi;
        start_wait(32'd999, 32'd10, 1'b0, lat1, st);
        @(posedge clk);
        #1;
        model(32'hFFFF_FC18, 32'd7, 1'b1, elo, ehi);
        start_wait(32'hFFFF_FC18, 32'd7, 1'b1, lat2, st);
        checks++;
        if (lat1 + 1 + lat2 !== 34 + 33 || result_lo !== elo || result_hi !== ehi) begin
            failures++;
            $display("FAIL back_to_back got lat1=%0d lat2=%0d lo=%h hi=%h exp 33 33 lo=%h hi=%h",
                     lat1, lat2, result_lo, result_hi, elo, ehi);
        end
        leave_ex();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_ext_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_iter_unit.md
# div_iter_unit

Iterative 32-bit radix-2 divider for the EX stage, serving DIV/DIVU. It is the producer of the EX-stage ALU stall (`alu_stallE`) consumed by the hazard unit. It obeys the hazard unit's exception flush and the cache-stall hold. While it works, it asserts the stall so EX/ID/IF freeze. It then holds its HI/LO result stable until the pipeline can advance.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `div_validE`  in  1  EX holds a DIV/DIVU.
  - Stays high while EX is stalled.
- `div_signedE`  in  1  1 = DIV (signed), 0 = DIVU.
- `src_aE`  in  WIDTH  dividend.
- `src_bE`  in  WIDTH  divisor.
- `flush_exceptionE`  in  1  exception flush; aborts any operation.
- `ext_stall`  in  1  cache stall (`i_cache_stall | d_cache_stall`); pipeline cannot advance.
- `alu_stallE`  out  1  divider needs more cycles.
- `div_doneE`  out  1  `result_hi`/`result_lo` valid this cycle.
- `result_lo`  out  WIDTH  quotient.
- `result_hi`  out  WIDTH  remainder.

## Operation
- States: IDLE, BUSY, DONE. Counter `cnt` is 5 bits for `WIDTH` = 32.
- IDLE:
  - `alu_stallE = div_validE & ~flush_exceptionE`, combinational, same cycle.
  - On `div_validE & ~flush_exceptionE`, latch `|a|` and `|b|`. Magnitudes are taken only when `div_signedE`; otherwise operands are taken raw.
  - Also latch `neg_q = sign(a)^sign(b)` and `neg_r = sign(a)`, each gated by `div_signedE`.
  - Clear the remainder register, set `cnt` = 0, go to BUSY.
- BUSY:
  - `alu_stallE` = 1.
  - Each cycle performs one restoring step: shift `{rem, quo}` left 1; trial `rem - |b|` at WIDTH+1 bits; if non-negative, keep the difference and set the quotient LSB.
  - `cnt` increments each step. After the step with `cnt` = WIDTH-1, go to DONE.
- DONE:
  - `alu_stallE` = 0, `div_doneE` = 1.
  - `result_lo = neg_q ? -quo : quo`; `result_hi = neg_r ? -rem : rem`.
  - Results are registered and held stable.
  - If `ext_stall` = 1, stay in DONE. Do not restart, even though `div_validE` is still high.
  - If `ext_stall` = 0, the instruction leaves EX this edge; go to IDLE.
- Flush: `flush_exceptionE` = 1 in any state forces IDLE next edge. `alu_stallE` drops the same cycle, and there is no result.
- Divisor zero:
  - `result_lo` = all ones, `result_hi` = raw dividend.
  - No sign fix-up is applied.
  - This is a deterministic value; the ISA leaves it undefined.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives `result_lo` = 0x80000000, `result_hi` = 0. This falls out of WIDTH+1 arithmetic.
- Reset: `rst` forces IDLE. All outputs are 0 and the result registers are cleared. Reset mid-BUSY discards the operation.

## Timing
- Cycle T: IDLE with `div_validE` = 1, so `alu_stallE` = 1.
- Cycles T+1 … T+32: BUSY, with `alu_stallE` = 1.
- Cycle T+33: DONE, `div_doneE` = 1, `alu_stallE` = 0.
- `alu_stallE` is high for exactly WIDTH+1 = 33 cycles.
- With `ext_stall` = 0 at T+33, the next instruction's `div_validE` is first seen in IDLE at T+34. Back-to-back divides are therefore spaced by 34 cycles.
- If flush and a new `div_validE` arrive in the same cycle, flush wins; nothing starts.
- Reset values:
  - State IDLE, `cnt` 0.
  - `alu_stallE`, `div_doneE`, `result_lo`, `result_hi` all 0.

## Configuration
- `DIV_ZERO_FAST_EN` defined:
  - A divisor of zero detected in IDLE goes directly to DONE next edge.
  - `alu_stallE` is high for cycle T only; `div_doneE` is high at T+1.
  - Results are the same zero-divisor values as above.
- Not defined: a zero divisor takes the full 33-cycle path. The results are identical.

## Test plan
- DIVU: 100 / 7 → `alu_stallE` high 33 cycles; at T+33, `result_lo` = 14, `result_hi` = 2, `div_doneE` = 1.
- DIV: −7 / 2 → `result_lo` = 0xFFFFFFFD, `result_hi` = 0xFFFFFFFF. Also 0x80000000 / −1 → `result_lo` = 0x80000000, `result_hi` = 0.
- `ext_stall` high for 5 cycles starting at T+33 → DONE held 5 extra cycles with results stable and no restart; IDLE the cycle after `ext_stall` falls.
- `flush_exceptionE` at T+10 → `alu_stallE` = 0 that cycle; IDLE at T+11. `div_doneE` is never asserted; a new divide afterwards gives correct results.
- Divisor 0, dividend 0x12345678 → `result_lo` = 0xFFFFFFFF, `result_hi` = 0x12345678.
  - With `DIV_ZERO_FAST_EN`: done at T+1.
  - Without it: done at T+33.
- `rst` at T+15 → all outputs 0 next cycle; IDLE.
